// File: rtl/riscv_muldiv_pkg.sv
// Shared types and encodings for the RV32M/RV64M iterative multiply/divide unit.
package riscv_muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/riscv_muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, sharing one 2*DATA_W shift register, RADIX_LOG2 bits retired per cycle.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned RADIX_LOG2 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  input  logic [REG_W-1:0]  rd_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [REG_W-1:0]  rd_out
);

  localparam int unsigned STEPS = DATA_W / RADIX_LOG2;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_t           state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [REG_W-1:0]        rd_q, rd_d;
  logic [DATA_W-1:0]       opd_q, opd_d;
  logic [2*DATA_W-1:0]     acc_q, acc_d;
  logic                    neg_q, neg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic [REG_W-1:0]        rd_out_q, rd_out_d;

  // Operand conditioning at launch.
  logic                    a_signed, b_signed, sa, sb, neg_start;
  logic [DATA_W-1:0]       mag_a, mag_b;
  logic                    div_zero, div_ovf, special;
  logic [DATA_W-1:0]       special_res;

  always_comb begin
    a_signed  = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed  = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sa        = a_signed & rs1[DATA_W-1];
    sb        = b_signed & rs2[DATA_W-1];
    mag_a     = sa ? -rs1 : rs1;
    mag_b     = sb ? -rs2 : rs2;
    // Remainder follows the dividend; products and quotients follow the sign XOR.
    neg_start = (funct3 == F3_REM) ? sa : (sa ^ sb);
    div_zero  = (rs2 == '0);
    div_ovf   = ~funct3[0] & (rs1 == MIN_VAL) & (rs2 == {DATA_W{1'b1}});
    special   = funct3[2] & (div_zero | div_ovf);
    if (div_zero) begin
      special_res = funct3[1] ? rs1 : {DATA_W{1'b1}};
    end else begin
      special_res = funct3[1] ? '0 : rs1;
    end
  end

  // One iteration of each datapath, computed from the shared accumulator.
  logic [DATA_W+RADIX_LOG2-1:0] mul_sum;
  logic [2*DATA_W-1:0]          mul_next, div_next;
  logic [DATA_W:0]              rem_w;
  logic [DATA_W-1:0]            quo_w;

  always_comb begin
    mul_sum = {{RADIX_LOG2{1'b0}}, acc_q[2*DATA_W-1:DATA_W]};
    for (int j = 0; j < RADIX_LOG2; j++) begin
      if (acc_q[j]) begin
        mul_sum = mul_sum + ({{RADIX_LOG2{1'b0}}, opd_q} << j);
      end
    end
    mul_next = {mul_sum, acc_q[DATA_W-1:RADIX_LOG2]};

    rem_w = {1'b0, acc_q[2*DATA_W-1:DATA_W]};
    quo_w = acc_q[DATA_W-1:0];
    for (int j = 0; j < RADIX_LOG2; j++) begin
      rem_w = {rem_w[DATA_W-1:0], quo_w[DATA_W-1]};
      quo_w = {quo_w[DATA_W-2:0], 1'b0};
      if (rem_w >= {1'b0, opd_q}) begin
        rem_w    = rem_w - {1'b0, opd_q};
        quo_w[0] = 1'b1;
      end
    end
    div_next = {rem_w[DATA_W-1:0], quo_w};
  end

  // Sign-corrected final value, used only on the last iteration.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_q ? -mul_next : mul_next;
    quo_fix  = neg_q ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
    rem_fix  = neg_q ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
    if (!op_q[2]) begin
      fin_res = (op_q[1:0] == 2'b00) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
    end else begin
      fin_res = op_q[1] ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opd_d    = opd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = funct3;
          rd_d  = rd_in;
          neg_d = neg_start;
          cnt_d = CNT_INIT;
          if (!funct3[2]) begin
            opd_d   = mag_a;
            acc_d   = {{DATA_W{1'b0}}, mag_b};
            state_d = MUL;
          end else begin
            opd_d = mag_b;
            acc_d = {{DATA_W{1'b0}}, mag_a};
            if (special) begin
              state_d  = DONE;
              result_d = special_res;
              rd_out_d = rd_in;
            end else begin
              state_d = DIV;
            end
          end
        end
      end
      MUL, DIV: begin
        acc_d = (state_q == MUL) ? mul_next : div_next;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = DONE;
          result_d = fin_res;
          rd_out_d = rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A flush must not disturb the last committed result.
    if (kill) begin
      state_d  = IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      opd_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opd_q    <= opd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: a 32-bit radix-2 and a 64-bit radix-4 instance.
module tb_riscv_muldiv_unit;
  import riscv_muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start_a, kill_a, busy_a, done_a;
  logic [2:0]  f3_a;
  logic [31:0] rs1_a, rs2_a, result_a;
  logic [4:0]  rd_a, rd_out_a;
  logic        start_b, kill_b, busy_b, done_b;
  logic [2:0]  f3_b;
  logic [63:0] rs1_b, rs2_b, result_b;
  logic [4:0]  rd_b, rd_out_b;

  riscv_muldiv_unit #(.DATA_W(32), .REG_W(5), .RADIX_LOG2(1)) u_dut32 (
    .clk(clk), .reset(reset), .start(start_a), .kill(kill_a), .funct3(f3_a),
    .rs1(rs1_a), .rs2(rs2_a), .rd_in(rd_a), .busy(busy_a), .done(done_a),
    .result(result_a), .rd_out(rd_out_a)
  );

  riscv_muldiv_unit #(.DATA_W(64), .REG_W(5), .RADIX_LOG2(2)) u_dut64 (
    .clk(clk), .reset(reset), .start(start_b), .kill(kill_b), .funct3(f3_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd_in(rd_b), .busy(busy_b), .done(done_b),
    .result(result_b), .rd_out(rd_out_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w64;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic cur_done(input bit w64);
    return w64 ? done_b : done_a;
  endfunction
  function automatic logic cur_busy(input bit w64);
    return w64 ? busy_b : busy_a;
  endfunction
  function automatic logic [63:0] cur_result(input bit w64);
    return w64 ? result_b : {32'b0, result_a};
  endfunction
  function automatic logic [4:0] cur_rd(input bit w64);
    return w64 ? rd_out_b : rd_out_a;
  endfunction

  // Reference: exact arithmetic on sign-extended operands, then truncation to w bits.
  function automatic logic [63:0] ref_model(input logic [2:0] f3, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
    logic signed [129:0] ea, eb, r;
    logic [63:0] mask;
    bit a_s, b_s;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a_s  = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    b_s  = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    ea   = {66'b0, a & mask};
    eb   = {66'b0, b & mask};
    if (a_s && a[w-1]) ea = ea - (130'sd1 <<< w);
    if (b_s && b[w-1]) eb = eb - (130'sd1 <<< w);
    if (f3[2] && eb == 0) return f3[1] ? (a & mask) : mask;
    case (f3)
      F3_MUL:                       r = ea * eb;
      F3_MULH, F3_MULHSU, F3_MULHU: r = (ea * eb) >>> w;
      F3_DIV, F3_DIVU:              r = ea / eb;
      default:                      r = ea % eb;
    endcase
    return r[63:0] & mask;
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [63:0] a,
                                    input logic [63:0] b, input int w);
    logic [63:0] mask, minv;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    minv = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    return f3[2] && (((b & mask) == 0) ||
                     (!f3[0] && (a & mask) == minv && (b & mask) == mask));
  endfunction

  // Launch one op, wait for done (bounded), and check result, tag, latency and pulse width.
  task automatic run_op(input bit w64, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                        input int exp_lat, input string tag);
    int cyc;
    logic seen;
    @(negedge clk);
    if (w64) begin
      start_b = 1'b1; f3_b = f3; rs1_b = a; rs2_b = b; rd_b = rd;
    end else begin
      start_a = 1'b1; f3_a = f3; rs1_a = a[31:0]; rs2_a = b[31:0]; rd_a = rd;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    cyc  = 0;
    seen = cur_done(w64);
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      seen = cur_done(w64);
    end
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"}, cur_result(w64), exp);
    check({tag, " rd_out"}, 64'(cur_rd(w64)), 64'(rd));
    check({tag, " busy in done"}, 64'(cur_busy(w64)), 64'd1);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 64'(cur_done(w64)), 64'd0);
    check({tag, " idle after"}, 64'(cur_busy(w64)), 64'd0);
    check({tag, " result held"}, cur_result(w64), exp);
  endtask

  initial begin
    int dones;
    reset = 1'b1;
    start_a = 0; kill_a = 0; f3_a = 0; rs1_a = 0; rs2_a = 0; rd_a = 0;
    start_b = 0; kill_b = 0; f3_b = 0; rs1_b = 0; rs2_b = 0; rd_b = 0;

    vecs[0]  = '{1'b0, F3_MUL,    64'h7,        64'hFFFF_FFFD, 64'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, F3_MULH,   64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 1'b0};
    vecs[2]  = '{1'b0, F3_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{1'b0, F3_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{1'b0, F3_DIV,    64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFD, 1'b0};
    vecs[5]  = '{1'b0, F3_REM,    64'hFFFF_FFF9, 64'h2,         64'hFFFF_FFFF, 1'b0};
    vecs[6]  = '{1'b0, F3_DIVU,   64'd100,       64'd7,         64'd14,        1'b0};
    vecs[7]  = '{1'b0, F3_REMU,   64'd100,       64'd7,         64'd2,         1'b0};
    vecs[8]  = '{1'b0, F3_DIVU,   64'd5,         64'd0,         64'hFFFF_FFFF, 1'b1};
    vecs[9]  = '{1'b0, F3_REM,    64'd5,         64'd0,         64'd5,         1'b1};
    vecs[10] = '{1'b0, F3_DIV,    64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1'b1};
    vecs[11] = '{1'b0, F3_REM,    64'h8000_0000, 64'hFFFF_FFFF, 64'd0,         1'b1};
    vecs[12] = '{1'b1, F3_MUL,    64'h1_0000_0000, 64'd3,       64'h3_0000_0000, 1'b0};
    vecs[13] = '{1'b1, F3_DIVU,   64'd1000,      64'd7,         64'd142,       1'b0};
    vecs[14] = '{1'b1, F3_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy32", 64'(busy_a), 64'd0);
    check("reset done32", 64'(done_a), 64'd0);
    check("reset result32", 64'(result_a), 64'd0);
    check("reset rd32", 64'(rd_out_a), 64'd0);
    check("reset busy64", 64'(busy_b), 64'd0);
    check("reset result64", result_b, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].w64, vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp,
             vecs[i].special ? 0 : 32, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      bit          w64;
      int          w;
      logic [2:0]  f3;
      logic [63:0] a, b, mask;
      int unsigned sel;
      w64  = (i >= 40);
      w    = w64 ? 64 : 32;
      mask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      f3   = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom} & mask;
      b    = {$urandom, $urandom} & mask;
      sel  = $urandom_range(0, 7);
      if (sel == 0) b = 64'd0;
      if (sel == 1) begin a = mask ^ (mask >> 1); b = mask; end
      if (sel == 2) b = b & 64'hFF;
      run_op(w64, f3, a, b, 5'($urandom_range(0, 31)), ref_model(f3, a, b, w),
             is_special(f3, a, b, w) ? 0 : 32, $sformatf("rand%0d", i));
    end

    // start held high through the whole operation: exactly one completion.
    dones = 0;
    @(negedge clk);
    start_a = 1'b1; f3_a = F3_MUL; rs1_a = 32'd7; rs2_a = 32'd3; rd_a = 5'd3;
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (done_a) begin
        dones++;
        start_a = 1'b0;
      end
    end
    start_a = 1'b0;
    check("held start single done", 64'(dones), 64'd1);
    check("held start result", 64'(result_a), 64'd21);

    // kill in cycle k+10 aborts a divide without touching result/rd_out.
    @(negedge clk);
    start_a = 1'b1; f3_a = F3_DIVU; rs1_a = 32'd100; rs2_a = 32'd7; rd_a = 5'd9;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill_a = 1'b1;
    @(posedge clk); #1;
    kill_a = 1'b0;
    check("kill busy", 64'(busy_a), 64'd0);
    check("kill done", 64'(done_a), 64'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check("kill no done", 64'(dones), 64'd0);
    check("kill result kept", 64'(result_a), 64'd21);
    check("kill rd kept", 64'(rd_out_a), 64'd3);

    // Reset in the middle of a multiply clears every output.
    @(negedge clk);
    start_a = 1'b1; f3_a = F3_MUL; rs1_a = 32'd5; rs2_a = 32'd6; rd_a = 5'd7;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset busy", 64'(busy_a), 64'd0);
    check("midreset done", 64'(done_a), 64'd0);
    check("midreset result", 64'(result_a), 64'd0);
    check("midreset rd", 64'(rd_out_a), 64'd0);

    run_op(1'b0, F3_MULHU, 64'hFFFF_FFFF, 64'h2, 5'd12, 64'd1, 32, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
